// File: rtl/fadd_sub_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fadd_sub_arbiter_pkg
// Shared definitions for the two-requester add/sub arbiter:
//   req_id_t - identifies which requester an operation belongs to
//   tag_t    - one entry of the in-flight tag pipeline {valid, id}
//   OP_ADD / OP_SUB - operation encoding seen on reqN_op and fpu_op
//   STAT_W   - width of the optional statistics counters
// ---------------------------------------------------------------------------
package fadd_sub_arbiter_pkg;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int STAT_W = 16;

endpackage

// File: rtl/fadd_sub_arbiter_if.sv
// ---------------------------------------------------------------------------
// fadd_sub_arbiter_if
// Bundles the requester handshakes, the response ports and the connection to
// the shared add/sub unit.
//   slave  modport : the arbiter's view (requests and unit result in,
//                    readies, responses and unit operands out)
//   master modport : the surrounding system's view (requesters plus unit)
// ---------------------------------------------------------------------------
interface fadd_sub_arbiter_if;

   // requester side
   logic        req0_valid;
   logic        req1_valid;
   logic        req0_ready;
   logic        req1_ready;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        req0_op;
   logic        req1_op;

   // response side
   logic        rsp0_valid;
   logic        rsp1_valid;
   logic [31:0] rsp0_data;
   logic [31:0] rsp1_data;
   logic        rsp0_ovf;
   logic        rsp0_unf;
   logic        rsp1_ovf;
   logic        rsp1_unf;

   // shared add/sub unit
   logic        fpu_en;
   logic [31:0] fpu_in1;
   logic [31:0] fpu_in2;
   logic        fpu_op;
   logic [31:0] fpu_out;
   logic        fpu_overflow;
   logic        fpu_underflow;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
             req0_op, req1_op, fpu_out, fpu_overflow, fpu_underflow,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
             rsp0_data, rsp1_data, rsp0_ovf, rsp0_unf, rsp1_ovf, rsp1_unf,
             fpu_en, fpu_in1, fpu_in2, fpu_op
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
             req0_op, req1_op, fpu_out, fpu_overflow, fpu_underflow,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
             rsp0_data, rsp1_data, rsp0_ovf, rsp0_unf, rsp1_ovf, rsp1_unf,
             fpu_en, fpu_in1, fpu_in2, fpu_op
   );

endinterface

// File: rtl/fadd_tag_pipe.sv
// ---------------------------------------------------------------------------
// fadd_tag_pipe
// Shift register of {valid, requester id} tags that travels alongside the
// shared add/sub unit so each result can be steered back to its requester.
//   clk, rst : clock, asynchronous active-high reset (clears every stage)
//   tag_in   : tag entering stage 0 (valid=0 for a bubble)
//   tag_tap  : stage DEPTH-2, aligned with the unit's result on fpu_out
//   tag_out  : stage DEPTH-1, aligned with the registered response
// DEPTH must be at least 2.
// ---------------------------------------------------------------------------
module fadd_tag_pipe
   import fadd_sub_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_tap,
   output tag_t tag_out
);

   tag_t stage_reg [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign tag_tap = stage_reg[DEPTH-2];
   assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/fadd_sub_arbiter.sv
// ---------------------------------------------------------------------------
// fadd_sub_arbiter
// Round-robin arbiter sharing one pipelined FP add/sub unit between two
// requesters. One operation issues per cycle; results come back in issue
// order as single-cycle pulses on the owning requester's response port.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fadd_sub_arbiter_if.slave (requests, responses, unit port)
//   stat0_grants, stat1_grants, stat_exc : optional counters, present only
//              when the FADD_ARB_STATS_EN macro is defined
// LATENCY counts clock edges from a handshake's operands being launched
// into fpu_in1/fpu_in2/fpu_op (that edge included) to the result on fpu_out;
// the response is registered one edge later, LATENCY+1 edges after the
// handshake.
// ---------------------------------------------------------------------------
module fadd_sub_arbiter
   import fadd_sub_arbiter_pkg::*;
#(
   parameter int LATENCY = 3
) (
   input  logic              clk,
   input  logic              rst,
   fadd_sub_arbiter_if.slave bus
`ifdef FADD_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat0_grants,
   output logic [STAT_W-1:0] stat1_grants,
   output logic [STAT_W-1:0] stat_exc
`endif
);

   req_id_t     prio_reg;
   logic        grant0;
   logic        grant1;
   logic        handshake;
   logic [31:0] in1_reg;
   logic [31:0] in2_reg;
   logic        op_reg;
   logic [31:0] rsp0_data_reg;
   logic [31:0] rsp1_data_reg;
   logic        rsp0_ovf_reg;
   logic        rsp0_unf_reg;
   logic        rsp1_ovf_reg;
   logic        rsp1_unf_reg;
   tag_t        tag_in;
   tag_t        tag_tap;
   tag_t        tag_out;

   // Grant: a lone requester always wins; on contention the priority holder
   // wins. Forced low during reset so no ready can leak out.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst) begin
         if (bus.req0_valid && (!bus.req1_valid || prio_reg == REQ0)) begin
            grant0 = 1'b1;
         end else if (bus.req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   // grants only assert with the matching valid, so grant == handshake
   assign handshake      = grant0 | grant1;
   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_reg <= REQ0;
         in1_reg  <= '0;
         in2_reg  <= '0;
         op_reg   <= OP_ADD;
      end else if (handshake) begin
         prio_reg <= grant0 ? REQ1 : REQ0;
         in1_reg  <= grant1 ? bus.req1_a  : bus.req0_a;
         in2_reg  <= grant1 ? bus.req1_b  : bus.req0_b;
         op_reg   <= grant1 ? bus.req1_op : bus.req0_op;
      end
   end

   // unit never stalls; only reset holds it
   assign bus.fpu_en  = ~rst;
   assign bus.fpu_in1 = in1_reg;
   assign bus.fpu_in2 = in2_reg;
   assign bus.fpu_op  = op_reg;

   // idle cycles push a bubble so tag position tracks unit position
   assign tag_in.valid = handshake;
   assign tag_in.id    = grant1 ? REQ1 : REQ0;

   fadd_tag_pipe #(
      .DEPTH (LATENCY + 1)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_tap (tag_tap),
      .tag_out (tag_out)
   );

   // tag_tap lines up with the unit result, so capture it into the owner's
   // response registers; the other port keeps its last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp0_data_reg <= '0;
         rsp1_data_reg <= '0;
         rsp0_ovf_reg  <= 1'b0;
         rsp0_unf_reg  <= 1'b0;
         rsp1_ovf_reg  <= 1'b0;
         rsp1_unf_reg  <= 1'b0;
      end else if (tag_tap.valid) begin
         if (tag_tap.id == REQ0) begin
            rsp0_data_reg <= bus.fpu_out;
            rsp0_ovf_reg  <= bus.fpu_overflow;
            rsp0_unf_reg  <= bus.fpu_underflow;
         end else begin
            rsp1_data_reg <= bus.fpu_out;
            rsp1_ovf_reg  <= bus.fpu_overflow;
            rsp1_unf_reg  <= bus.fpu_underflow;
         end
      end
   end

   assign bus.rsp0_valid = tag_out.valid && (tag_out.id == REQ0);
   assign bus.rsp1_valid = tag_out.valid && (tag_out.id == REQ1);
   assign bus.rsp0_data  = rsp0_data_reg;
   assign bus.rsp1_data  = rsp1_data_reg;
   assign bus.rsp0_ovf   = rsp0_ovf_reg;
   assign bus.rsp0_unf   = rsp0_unf_reg;
   assign bus.rsp1_ovf   = rsp1_ovf_reg;
   assign bus.rsp1_unf   = rsp1_unf_reg;

`ifdef FADD_ARB_STATS_EN
   logic [STAT_W-1:0] stat0_reg;
   logic [STAT_W-1:0] stat1_reg;
   logic [STAT_W-1:0] exc_reg;
   logic              exc_event;

   assign exc_event = (bus.rsp0_valid && (rsp0_ovf_reg || rsp0_unf_reg)) ||
                      (bus.rsp1_valid && (rsp1_ovf_reg || rsp1_unf_reg));

   // counters wrap naturally at 2**STAT_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat0_reg <= '0;
         stat1_reg <= '0;
         exc_reg   <= '0;
      end else begin
         if (grant0)    stat0_reg <= stat0_reg + 1'b1;
         if (grant1)    stat1_reg <= stat1_reg + 1'b1;
         if (exc_event) exc_reg   <= exc_reg + 1'b1;
      end
   end

   assign stat0_grants = stat0_reg;
   assign stat1_grants = stat1_reg;
   assign stat_exc     = exc_reg;
`endif

endmodule

// File: tb/tb_fadd_sub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fadd_sub_arbiter
// Directed bench for fadd_sub_arbiter with LATENCY=3. The shared add/sub unit
// is a small table of hand-computed IEEE-754 results behind a LATENCY-1 deep
// register pipeline; responses are logged by cycle number and checked per
// scenario. Builds with or without FADD_ARB_STATS_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fadd_sub_arbiter;
   import fadd_sub_arbiter_pkg::*;

   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fadd_sub_arbiter_if bus ();

`ifdef FADD_ARB_STATS_EN
   logic [15:0] stat0_grants;
   logic [15:0] stat1_grants;
   logic [15:0] stat_exc;
`endif

   fadd_sub_arbiter #(
      .LATENCY (LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus)
`ifdef FADD_ARB_STATS_EN
      ,
      .stat0_grants (stat0_grants),
      .stat1_grants (stat1_grants),
      .stat_exc     (stat_exc)
`endif
   );

   // ---- add/sub unit model: {ovf, unf, result} from a hand-computed table
   function automatic logic [33:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic op);
      case ({op, a, b})
         {1'b0, 32'h3f800000, 32'h40000000}: return {2'b00, 32'h40400000}; // 1+2=3
         {1'b1, 32'h40400000, 32'h3f800000}: return {2'b00, 32'h40000000}; // 3-1=2
         {1'b0, 32'h3f800000, 32'h3f800000}: return {2'b00, 32'h40000000}; // 1+1=2
         {1'b1, 32'h40000000, 32'h3f800000}: return {2'b00, 32'h3f800000}; // 2-1=1
         {1'b0, 32'h40000000, 32'h40000000}: return {2'b00, 32'h40800000}; // 2+2=4
         {1'b1, 32'h40800000, 32'h3f800000}: return {2'b00, 32'h40400000}; // 4-1=3
         {1'b0, 32'h7f7fffff, 32'h7f7fffff}: return {2'b10, 32'h7f800000}; // max+max
         {1'b1, 32'h00800000, 32'h007fffff}: return {2'b01, 32'h00000001}; // tiny
         default:                            return {2'b00, 32'hdeadbeef};
      endcase
   endfunction

   logic [33:0] fpu_pipe [LAT-1];
   always @(posedge clk) begin
      if (bus.fpu_en) begin
         fpu_pipe[0] <= fpu_model(bus.fpu_in1, bus.fpu_in2, bus.fpu_op);
         for (int i = 1; i < LAT - 1; i++) fpu_pipe[i] <= fpu_pipe[i-1];
      end
   end
   assign bus.fpu_overflow  = fpu_pipe[LAT-2][33];
   assign bus.fpu_underflow = fpu_pipe[LAT-2][32];
   assign bus.fpu_out       = fpu_pipe[LAT-2][31:0];

   // ---- response log
   typedef struct {
      int          cyc;
      logic        port;
      logic [31:0] data;
      logic        ovf;
      logic        unf;
   } rsp_t;
   rsp_t rsp_q[$];

   always @(negedge clk) begin : mon
      rsp_t e;
      if (bus.rsp0_valid) begin
         e.cyc = cyc; e.port = 1'b0; e.data = bus.rsp0_data;
         e.ovf = bus.rsp0_ovf; e.unf = bus.rsp0_unf;
         rsp_q.push_back(e);
         $display("rsp  cyc=%0d port=0 data=%h ovf=%b unf=%b", cyc, e.data, e.ovf, e.unf);
      end
      if (bus.rsp1_valid) begin
         e.cyc = cyc; e.port = 1'b1; e.data = bus.rsp1_data;
         e.ovf = bus.rsp1_ovf; e.unf = bus.rsp1_unf;
         rsp_q.push_back(e);
         $display("rsp  cyc=%0d port=1 data=%h ovf=%b unf=%b", cyc, e.data, e.ovf, e.unf);
      end
   end

   function automatic logic [137:0] outs_vec();
      return {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
              bus.rsp0_data, bus.rsp1_data, bus.rsp0_ovf, bus.rsp0_unf,
              bus.rsp1_ovf, bus.rsp1_unf, bus.fpu_en, bus.fpu_in1, bus.fpu_in2,
              bus.fpu_op};
   endfunction

   task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic op);
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
   endtask

   task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic op);
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      set_req0(1'b0, 32'h0, 32'h0, OP_ADD);
      set_req1(1'b0, 32'h0, 32'h0, OP_ADD);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rsp_q.delete();
   endtask

   // ---- scenarios
   task automatic test_reset();
      rst = 1'b1;
      set_req0(1'b1, 32'h3f800000, 32'h40000000, OP_ADD);
      set_req1(1'b1, 32'h40400000, 32'h3f800000, OP_SUB);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (outs_vec() !== '0) begin
         failures++; $display("FAIL reset_outputs: got %h expected 0", outs_vec());
      end
`ifdef FADD_ARB_STATS_EN
      checks++;
      if ({stat0_grants, stat1_grants, stat_exc} !== 48'h0) begin
         failures++; $display("FAIL reset_stats: got %h expected 0",
                              {stat0_grants, stat1_grants, stat_exc});
      end
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.fpu_en !== 1'b1) begin
         failures++; $display("FAIL release_fpu_en: got %b expected 1", bus.fpu_en);
      end
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         failures++; $display("FAIL release_prio: got ready=%b%b expected 10",
                              bus.req0_ready, bus.req1_ready);
      end
      set_req0(1'b0, 32'h0, 32'h0, OP_ADD);
      set_req1(1'b0, 32'h0, 32'h0, OP_ADD);
      repeat (8) @(negedge clk);
      #1;
      checks++;
      if (rsp_q.size() != 0) begin
         failures++; $display("FAIL reset_no_rsp: got %0d pulses expected 0", rsp_q.size());
      end
      $display("done test_reset");
   endtask

   task automatic test_single();
      int t;
      rsp_q.delete();
      @(negedge clk);
      set_req0(1'b1, 32'h3f800000, 32'h40000000, OP_ADD);
      #1;
      t = cyc;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         failures++; $display("FAIL single_ready: got %b%b expected 10",
                              bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      set_req0(1'b0, 32'h0, 32'h0, OP_ADD);
      #1;
      checks++;
      if ({bus.fpu_in1, bus.fpu_in2, bus.fpu_op} !== {32'h3f800000, 32'h40000000, OP_ADD}) begin
         failures++; $display("FAIL single_fpu_in: got %h %h %b expected 3f800000 40000000 0",
                              bus.fpu_in1, bus.fpu_in2, bus.fpu_op);
      end
      repeat (8) @(negedge clk);
      #1;
      checks++;
      if (rsp_q.size() != 1) begin
         failures++; $display("FAIL single_count: got %0d pulses expected 1", rsp_q.size());
      end else begin
         checks++;
         if (rsp_q[0].cyc != t + LAT + 1 || rsp_q[0].port !== 1'b0 ||
             rsp_q[0].data !== 32'h40400000 || rsp_q[0].ovf !== 1'b0 || rsp_q[0].unf !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp: got cyc=%0d port=%b data=%h ovf=%b unf=%b expected cyc=%0d port=0 data=40400000 ovf=0 unf=0",
                     rsp_q[0].cyc, rsp_q[0].port, rsp_q[0].data, rsp_q[0].ovf, rsp_q[0].unf, t + LAT + 1);
         end
      end
      checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp0_data !== 32'h40400000) begin
         failures++; $display("FAIL single_hold: got valid=%b data=%h expected valid=0 data=40400000",
                              bus.rsp0_valid, bus.rsp0_data);
      end
      $display("done test_single");
   endtask

   task automatic test_round_robin();
      logic [31:0] a0 [2];
      logic [31:0] b0 [2];
      logic [31:0] a1 [2];
      logic [31:0] b1 [2];
      logic [31:0] exp_data [4];
      int   i0, i1, t0;
      logic exp_id;
      apply_reset();
      a0[0] = 32'h3f800000; b0[0] = 32'h3f800000;   // 1+1
      a0[1] = 32'h40000000; b0[1] = 32'h40000000;   // 2+2
      a1[0] = 32'h40000000; b1[0] = 32'h3f800000;   // 2-1
      a1[1] = 32'h40800000; b1[1] = 32'h3f800000;   // 4-1
      exp_data[0] = 32'h40000000; exp_data[1] = 32'h3f800000;
      exp_data[2] = 32'h40800000; exp_data[3] = 32'h40400000;
      i0 = 0; i1 = 0; t0 = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         set_req0(1'b1, a0[i0], b0[i0], OP_ADD);
         set_req1(1'b1, a1[i1], b1[i1], OP_SUB);
         #1;
         if (k == 0) t0 = cyc;
         exp_id = (k % 2) == 1;
         checks++;
         if ({bus.req0_ready, bus.req1_ready} !== {~exp_id, exp_id}) begin
            failures++; $display("FAIL rr_grant%0d: got ready=%b%b expected %b%b", k,
                                 bus.req0_ready, bus.req1_ready, ~exp_id, exp_id);
         end
         if (exp_id) i1++; else i0++;
      end
      @(negedge clk);
      set_req0(1'b0, 32'h0, 32'h0, OP_ADD);
      set_req1(1'b0, 32'h0, 32'h0, OP_ADD);
      repeat (8) @(negedge clk);
      #1;
      checks++;
      if (rsp_q.size() != 4) begin
         failures++; $display("FAIL rr_count: got %0d pulses expected 4", rsp_q.size());
      end
      for (int k = 0; k < 4 && k < rsp_q.size(); k++) begin
         checks++;
         if (rsp_q[k].cyc != t0 + LAT + 1 + k || rsp_q[k].port !== ((k % 2) == 1) ||
             rsp_q[k].data !== exp_data[k] || rsp_q[k].ovf !== 1'b0 || rsp_q[k].unf !== 1'b0) begin
            failures++;
            $display("FAIL rr_rsp%0d: got cyc=%0d port=%b data=%h expected cyc=%0d port=%0d data=%h",
                     k, rsp_q[k].cyc, rsp_q[k].port, rsp_q[k].data, t0 + LAT + 1 + k, k % 2, exp_data[k]);
         end
      end
`ifdef FADD_ARB_STATS_EN
      checks++;
      if (stat0_grants !== 16'd2 || stat1_grants !== 16'd2) begin
         failures++; $display("FAIL rr_stats: got %0d/%0d expected 2/2", stat0_grants, stat1_grants);
      end
`endif
      $display("done test_round_robin");
   endtask

   task automatic test_subtract();
      int t;
      rsp_q.delete();
      @(negedge clk);
      set_req1(1'b1, 32'h40400000, 32'h3f800000, OP_SUB);
      #1;
      t = cyc;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
         failures++; $display("FAIL sub_ready: got %b%b expected 01", bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      set_req1(1'b0, 32'h0, 32'h0, OP_ADD);
      repeat (8) @(negedge clk);
      #1;
      checks++;
      if (rsp_q.size() != 1) begin
         failures++; $display("FAIL sub_count: got %0d pulses expected 1", rsp_q.size());
      end else begin
         checks++;
         if (rsp_q[0].cyc != t + LAT + 1 || rsp_q[0].port !== 1'b1 || rsp_q[0].data !== 32'h40000000) begin
            failures++; $display("FAIL sub_rsp: got cyc=%0d port=%b data=%h expected cyc=%0d port=1 data=40000000",
                                 rsp_q[0].cyc, rsp_q[0].port, rsp_q[0].data, t + LAT + 1);
         end
      end
      $display("done test_subtract");
   endtask

   task automatic test_exceptions();
`ifdef FADD_ARB_STATS_EN
      logic [15:0] exc0;
      exc0 = stat_exc;
`endif
      rsp_q.delete();
      @(negedge clk);
      set_req0(1'b1, 32'h7f7fffff, 32'h7f7fffff, OP_ADD);
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1) begin
         failures++; $display("FAIL exc_ready0: got %b expected 1", bus.req0_ready);
      end
      @(negedge clk);
      set_req0(1'b0, 32'h0, 32'h0, OP_ADD);
      set_req1(1'b1, 32'h00800000, 32'h007fffff, OP_SUB);
      #1;
      checks++;
      if (bus.req1_ready !== 1'b1) begin
         failures++; $display("FAIL exc_ready1: got %b expected 1", bus.req1_ready);
      end
      @(negedge clk);
      set_req1(1'b0, 32'h0, 32'h0, OP_ADD);
      repeat (8) @(negedge clk);
      #1;
      checks++;
      if (rsp_q.size() != 2) begin
         failures++; $display("FAIL exc_count: got %0d pulses expected 2", rsp_q.size());
      end else begin
         checks++;
         if (rsp_q[0].port !== 1'b0 || rsp_q[0].data !== 32'h7f800000 ||
             rsp_q[0].ovf !== 1'b1 || rsp_q[0].unf !== 1'b0) begin
            failures++; $display("FAIL exc_ovf: got port=%b data=%h ovf=%b unf=%b expected port=0 data=7f800000 ovf=1 unf=0",
                                 rsp_q[0].port, rsp_q[0].data, rsp_q[0].ovf, rsp_q[0].unf);
         end
         checks++;
         if (rsp_q[1].port !== 1'b1 || rsp_q[1].data !== 32'h00000001 ||
             rsp_q[1].ovf !== 1'b0 || rsp_q[1].unf !== 1'b1 || rsp_q[1].cyc != rsp_q[0].cyc + 1) begin
            failures++; $display("FAIL exc_unf: got port=%b data=%h ovf=%b unf=%b cyc=%0d expected port=1 data=00000001 ovf=0 unf=1 cyc=%0d",
                                 rsp_q[1].port, rsp_q[1].data, rsp_q[1].ovf, rsp_q[1].unf,
                                 rsp_q[1].cyc, rsp_q[0].cyc + 1);
         end
      end
`ifdef FADD_ARB_STATS_EN
      checks++;
      if (stat_exc !== exc0 + 16'd2) begin
         failures++; $display("FAIL exc_stat: got %0d expected %0d", stat_exc, exc0 + 16'd2);
      end
`endif
      $display("done test_exceptions");
   endtask

   task automatic test_idle_gaps();
      int t;
      rsp_q.delete();
      @(negedge clk);
      set_req0(1'b1, 32'h3f800000, 32'h40000000, OP_ADD);
      #1;
      t = cyc;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         set_req0(1'b0, 32'h11111111, 32'h22222222, OP_SUB);
         #1;
         checks++;
         if ({bus.fpu_in1, bus.fpu_in2, bus.fpu_op} !== {32'h3f800000, 32'h40000000, OP_ADD}) begin
            failures++; $display("FAIL gap_hold%0d: got %h %h %b expected 3f800000 40000000 0",
                                 k, bus.fpu_in1, bus.fpu_in2, bus.fpu_op);
         end
      end
      @(negedge clk);
      set_req0(1'b1, 32'h40000000, 32'h40000000, OP_ADD);
      @(negedge clk);
      set_req0(1'b0, 32'h0, 32'h0, OP_ADD);
      repeat (8) @(negedge clk);
      #1;
      checks++;
      if (rsp_q.size() != 2) begin
         failures++; $display("FAIL gap_count: got %0d pulses expected 2", rsp_q.size());
      end else begin
         checks++;
         if (rsp_q[0].cyc != t + LAT + 1 || rsp_q[0].data !== 32'h40400000 ||
             rsp_q[1].cyc != t + LAT + 4 || rsp_q[1].data !== 32'h40800000) begin
            failures++; $display("FAIL gap_rsp: got %0d:%h %0d:%h expected %0d:40400000 %0d:40800000",
                                 rsp_q[0].cyc, rsp_q[0].data, rsp_q[1].cyc, rsp_q[1].data,
                                 t + LAT + 1, t + LAT + 4);
         end
      end
      $display("done test_idle_gaps");
   endtask

   task automatic test_reset_midflight();
      rsp_q.delete();
      @(negedge clk);
      set_req0(1'b1, 32'h3f800000, 32'h3f800000, OP_ADD);
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1) begin
         failures++; $display("FAIL mid_ready: got %b expected 1", bus.req0_ready);
      end
      @(negedge clk);
      set_req0(1'b0, 32'h0, 32'h0, OP_ADD);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (outs_vec() !== '0) begin
         failures++; $display("FAIL mid_outputs: got %h expected 0", outs_vec());
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if (rsp_q.size() != 0) begin
         failures++; $display("FAIL mid_no_rsp: got %0d pulses expected 0", rsp_q.size());
      end
      $display("done test_reset_midflight");
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_subtract();
      test_exceptions();
      test_idle_gaps();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fadd_sub_arbiter.md
FADD_SUB_ARBITER -- requirements
Module: fadd_sub_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 3: clock edges from operands on fpu_in1/fpu_in2/fpu_op to the result on fpu_out/fpu_overflow/fpu_underflow.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 each: requester i presents an operation.
REQ-005 The block SHALL have ports req0_ready/req1_ready, output, 1 each: the operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 each: IEEE-754 single-precision operands.
REQ-007 The block SHALL have ports req0_op/req1_op, input, 1 each: 0 = add, 1 = subtract.
REQ-008 The block SHALL have ports rsp0_valid/rsp1_valid, output, 1 each: a one-cycle result pulse with no backpressure.
REQ-009 The block SHALL have ports rsp0_data/rsp1_data, output, 32 each: the result.
REQ-010 The block SHALL have ports rsp0_ovf, rsp0_unf, rsp1_ovf, rsp1_unf, output, 1 each: overflow and underflow flags for the result.
REQ-011 The block SHALL have port fpu_en, output, 1: pipeline advance enable to the shared add/sub unit.
REQ-012 The block SHALL have ports fpu_in1/fpu_in2, output, 32 each, and fpu_op, output, 1: the unit's operands and operation.
REQ-013 The block SHALL have ports fpu_out, input, 32, and fpu_overflow/fpu_underflow, input, 1 each: the unit's result.

Function
REQ-014 A handshake on requester i SHALL occur in any cycle where reqi_valid and reqi_ready are both 1.
REQ-015 reqi_ready SHALL be combinational: 1 only for the granted requester, and never 1 for both requesters in the same cycle.
REQ-016 Arbitration SHALL be round-robin: a single valid requester is granted; when both are valid, the priority holder is granted.
REQ-017 The priority pointer SHALL move to the other requester after each handshake and SHALL hold when no handshake occurs.
REQ-018 On a handshake, the granted a/b/op SHALL be registered into fpu_in1/fpu_in2/fpu_op; with no handshake, those outputs SHALL hold their previous values.
REQ-019 fpu_en SHALL be 1 in every cycle while rst is 0, and the unit is never stalled.
REQ-020 A tag pipeline of LATENCY+1 stages SHALL carry {valid, requester id}; a bubble (valid=0) SHALL enter it in cycles with no handshake.
REQ-021 For a handshake in cycle t, rspi_valid SHALL pulse in cycle t+LATENCY+1, with rspi_data/ovf/unf registered from fpu_out/fpu_overflow/fpu_underflow.
REQ-022 Throughput SHALL be one operation per cycle across both requesters, and results SHALL return in issue order.
REQ-023 When rspi_valid is 0, rspi_data/ovf/unf SHALL hold their last values.

Reset
REQ-024 While rst is 1, the block SHALL clear all tag stages, set the priority pointer to requester 0, and drive every output to 0 (including fpu_en, reqi_ready and rspi_valid).
REQ-025 Operations in flight when reset asserts SHALL be discarded, and no response pulse SHALL follow reset release for them.

Configuration
REQ-026 With FADD_ARB_STATS_EN defined, the block SHALL add outputs stat0_grants and stat1_grants (16 each; increment per handshake; wrap from 0xFFFF to 0) and stat_exc (16; increments per response with ovf or unf set; wrap from 0xFFFF to 0), all reset to 0.
REQ-027 Without FADD_ARB_STATS_EN, those ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold the requester-id type, the op encoding constants (OP_ADD=0, OP_SUB=1) and the stats counter width.
REQ-029 The tag pipeline SHALL be a sub-module named fadd_tag_pipe, parameterised by depth.

Verification
REQ-030 Single request, LATENCY=3: req0 in cycle 5 with a=3f800000, b=40000000, op=0 -> rsp0_valid only in cycle 9, data=40400000, ovf=0, unf=0.
REQ-031 Both requesters valid for 4 cycles after reset -> grants go 0,1,0,1, and the responses arrive on the matching rsp port in that order, back to back.
REQ-032 Subtract, req1: a=40400000, b=3f800000, op=1 -> rsp1_data=40000000.
REQ-033 Overflow: a=b=7f7fffff, op=0 -> rsp0_ovf=1, and stat_exc increments when FADD_ARB_STATS_EN is defined.
REQ-034 Reset mid-flight: assert rst 2 cycles after a handshake -> all outputs 0 immediately, and no rsp pulse after release.
REQ-035 Idle gaps: requests in cycles 5 and 8 only -> a single rsp pulse for each, fpu_in1/fpu_in2/fpu_op held steady in cycles 6-7, no spurious rsp pulses.
